// File: rtl/ring_phase_monitor_pkg.sv
// Shared types and helpers for the ring phase monitor: FSM state, fault codes,
// ring rotation and one-hot test on a width-agnostic vector.
package ring_mon_pkg;

  localparam int MAX_N = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_CORRUPT = 2'b01;
  localparam logic [1:0] FC_SKIP    = 2'b10;
  localparam logic [1:0] FC_STALL   = 2'b11;

  // Rotates the low n bits of vec by one place; dir=1 left, dir=0 right.
  function automatic logic [MAX_N-1:0] rot(input logic [MAX_N-1:0] vec,
                                           input int n, input logic dir);
    logic [MAX_N-1:0] res;
    int src;
    res = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        src    = dir ? ((i + n - 1) % n) : ((i + 1) % n);
        res[i] = vec[src];
      end
    end
    return res;
  endfunction

  function automatic logic is_onehot(input logic [MAX_N-1:0] vec);
    return $onehot(vec);
  endfunction

endpackage

// File: rtl/ring_phase_monitor_if.sv
// Bundle between the ring counter (master drives count_in) and the monitor
// (slave returns phase/revolution/fault status).
interface ring_phase_monitor_if #(
  parameter int N     = 4,
  parameter int REV_W = 8
);
  logic [N-1:0]          count_in;
  logic [$clog2(N)-1:0]  phase_idx;
  logic                  phase_valid;
  logic                  rev_tick;
  logic [REV_W-1:0]      rev_count;
  logic                  fault;
  logic [1:0]            fault_code;

  modport master (
    output count_in,
    input  phase_idx, phase_valid, rev_tick, rev_count, fault, fault_code
  );

  modport slave (
    input  count_in,
    output phase_idx, phase_valid, rev_tick, rev_count, fault, fault_code
  );
endinterface

// File: rtl/ring_phase_monitor_encoder.sv
// Combinational one-hot to binary encoder; o_idx is meaningless when o_valid=0.
module onehot_encoder
  import ring_mon_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_vec,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_valid
);
  localparam int IDX_W = $clog2(N);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_valid = is_onehot(MAX_N'(i_vec));
endmodule

// File: rtl/ring_phase_monitor.sv
// Ring counter phase monitor; RING_MON_RESYNC_EN lets FAULT recover after RESYNC_LEN good steps.
// state | meaning: IDLE waits for first one-hot | TRACK ring rotating cleanly | FAULT first bad sample latched
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int N          = 4,
  parameter int ROT_LEFT   = 1,
  parameter int REV_W      = 8,
  parameter int RESYNC_LEN = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  ring_phase_monitor_if.slave  bus
);
  localparam int IDX_W = $clog2(N);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("ring_phase_monitor: N out of range");
  end
  if (RESYNC_LEN < 1) begin : g_bad_resync
    $error("ring_phase_monitor: RESYNC_LEN must be >= 1");
  end

  state_t              r_state, w_state_nxt;
  logic [N-1:0]        r_prev, w_prev_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic                r_tick, w_tick_nxt;
  logic [REV_W-1:0]    r_rev, w_rev_nxt;
  logic [1:0]          r_code, w_code_nxt;

  logic [N-1:0]        w_in;
  logic [N-1:0]        w_exp;
  logic [IDX_W-1:0]    w_enc_idx;
  logic                w_onehot;
  logic                w_good;
  logic                w_wrap;

  assign w_in  = bus.count_in;
  assign w_exp = N'(rot(MAX_N'(r_prev), N, (ROT_LEFT != 0)));

  onehot_encoder #(.N(N)) u_enc (
    .i_vec   (w_in),
    .o_idx   (w_enc_idx),
    .o_valid (w_onehot)
  );

  // rot() of a one-hot prev is one-hot and differs from prev, so equality suffices
  assign w_good = w_onehot && (w_in == w_exp);
  assign w_wrap = (ROT_LEFT != 0) ? (r_prev[N-1] && w_in[0]) : (r_prev[0] && w_in[N-1]);

`ifdef RING_MON_RESYNC_EN
  localparam int RC_W = $clog2(RESYNC_LEN + 1);
  logic [RC_W-1:0] r_resync, w_resync_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_prev_nxt  = r_prev;
    w_idx_nxt   = '0;
    w_tick_nxt  = 1'b0;
    w_rev_nxt   = r_rev;
    w_code_nxt  = r_code;
`ifdef RING_MON_RESYNC_EN
    w_resync_nxt = r_resync;
`endif
    case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_state_nxt = TRACK;
          w_prev_nxt  = w_in;
          w_idx_nxt   = w_enc_idx;
        end
      end
      TRACK: begin
        w_prev_nxt = w_in;
`ifdef RING_MON_RESYNC_EN
        w_resync_nxt = '0;
`endif
        if (!w_onehot) begin
          w_state_nxt = FAULT;
          w_code_nxt  = FC_CORRUPT;
        end else if (w_in == r_prev) begin
          w_state_nxt = FAULT;
          w_code_nxt  = FC_STALL;
        end else if (!w_good) begin
          w_state_nxt = FAULT;
          w_code_nxt  = FC_SKIP;
        end else begin
          w_idx_nxt = w_enc_idx;
          if (w_wrap) begin
            w_tick_nxt = 1'b1;
            w_rev_nxt  = r_rev + REV_W'(1);
          end
        end
      end
      FAULT: begin
        w_prev_nxt = w_in;
`ifdef RING_MON_RESYNC_EN
        if (w_good) begin
          if (r_resync == RC_W'(RESYNC_LEN - 1)) begin
            w_state_nxt  = TRACK;
            w_code_nxt   = FC_NONE;
            w_idx_nxt    = w_enc_idx;
            w_resync_nxt = '0;
          end else begin
            w_resync_nxt = r_resync + RC_W'(1);
          end
        end else begin
          w_resync_nxt = '0;
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_prev_nxt  = '0;
        w_code_nxt  = FC_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_idx   <= '0;
      r_tick  <= 1'b0;
      r_rev   <= '0;
      r_code  <= FC_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= w_prev_nxt;
      r_idx   <= w_idx_nxt;
      r_tick  <= w_tick_nxt;
      r_rev   <= w_rev_nxt;
      r_code  <= w_code_nxt;
    end
  end

`ifdef RING_MON_RESYNC_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_resync <= '0;
    else     r_resync <= w_resync_nxt;
  end
`endif

  assign bus.phase_idx   = r_idx;
  assign bus.phase_valid = (r_state == TRACK);
  assign bus.fault       = (r_state == FAULT);
  assign bus.rev_tick    = r_tick;
  assign bus.rev_count   = r_rev;
  assign bus.fault_code  = r_code;
endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed plus random bench for ring_phase_monitor (N=4, rotate left, REV_W=8, RESYNC_LEN=4).
module tb_ring_phase_monitor;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  ring_phase_monitor_if #(.N(4), .REV_W(8)) bus ();

  ring_phase_monitor #(.N(4), .ROT_LEFT(1), .REV_W(8), .RESYNC_LEN(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Reference model: mode 0 idle, 1 tracking, 2 faulted
  int         m_mode, m_idx, m_code, m_rev, m_tick, m_good_run;
  logic [3:0] m_prev;

  function automatic int ph(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_code = 0; m_rev = 0; m_tick = 0; m_good_run = 0; m_prev = 4'b0;
  endtask

  task automatic model_edge(input logic [3:0] v);
    bit oh, good;
    int old_mode;
    oh   = ($countones(v) == 1);
    good = oh && ($countones(m_prev) == 1) && (ph(v) == (ph(m_prev) + 1) % 4);
    old_mode = m_mode;
    m_tick = 0;
    if (m_mode == 0) begin
      if (oh) begin m_mode = 1; m_idx = ph(v); end
    end else if (m_mode == 1) begin
      m_good_run = 0;
      if (!oh)             begin m_mode = 2; m_code = 1; end
      else if (v == m_prev) begin m_mode = 2; m_code = 3; end
      else if (!good)      begin m_mode = 2; m_code = 2; end
      else begin
        m_idx = ph(v);
        if (ph(m_prev) == 3 && ph(v) == 0) begin m_tick = 1; m_rev = (m_rev + 1) % 256; end
      end
    end else begin
`ifdef RING_MON_RESYNC_EN
      if (good) begin
        m_good_run++;
        if (m_good_run == 4) begin m_mode = 1; m_code = 0; m_idx = ph(v); m_good_run = 0; end
      end else m_good_run = 0;
`endif
    end
    if (old_mode != 0 || oh) m_prev = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("phase_idx",   32'(bus.phase_idx),   (m_mode == 1) ? 32'(m_idx) : 32'd0);
    chk("phase_valid", 32'(bus.phase_valid), 32'(m_mode == 1));
    chk("fault",       32'(bus.fault),       32'(m_mode == 2));
    chk("fault_code",  32'(bus.fault_code),  32'(m_code));
    chk("rev_tick",    32'(bus.rev_tick),    32'(m_tick));
    chk("rev_count",   32'(bus.rev_count),   32'(m_rev));
  endtask

  task automatic step(input logic [3:0] v);
    @(negedge clk);
    bus.count_in = v;
    @(posedge clk);
    model_edge(v);
    #1 check_all();
  endtask

  // Called right after step(): clr pulse lands strictly between clock edges.
  task automatic async_clr();
    #1 clr = 1'b1;
    model_reset();
    #1 check_all();
    chk("clr_zero", {bus.phase_idx, bus.phase_valid, bus.rev_tick, bus.rev_count,
                     bus.fault, bus.fault_code}, 32'd0);
    #1 clr = 1'b0;
  endtask

  logic [3:0] last_v;
  logic [3:0] rv;
  logic [3:0] seq2 [5];

  initial begin
    bus.count_in = 4'b0;
    model_reset();
    #1 check_all();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    clr = 1'b0;

    // 1: unloaded ring stays idle
    repeat (3) step(4'b0000);
    chk("idle_valid", 32'(bus.phase_valid), 32'd0);
    chk("idle_fault", 32'(bus.fault), 32'd0);

    // 2: first revolution
    seq2[0] = 4'b0001; seq2[1] = 4'b0010; seq2[2] = 4'b0100; seq2[3] = 4'b1000; seq2[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(seq2[i]);
      chk("rev1_idx", 32'(bus.phase_idx), 32'(i % 4));
      chk("rev1_tick", 32'(bus.rev_tick), 32'(i == 4));
    end
    chk("rev1_count", 32'(bus.rev_count), 32'd1);

    // 3: corrupt, then stall must not overwrite the code
    step(4'b0010);
    step(4'b0100);
    step(4'b0101);
    chk("corrupt_fault", 32'(bus.fault), 32'd1);
    chk("corrupt_code", 32'(bus.fault_code), 32'd1);
    chk("corrupt_valid", 32'(bus.phase_valid), 32'd0);
    step(4'b0101);
    chk("corrupt_hold", 32'(bus.fault_code), 32'd1);
    chk("rev_frozen", 32'(bus.rev_count), 32'd1);

    // 4a: skip
    async_clr();
    step(4'b0001);
    step(4'b0100);
    chk("skip_code", 32'(bus.fault_code), 32'd2);
    // 4b: stall
    async_clr();
    step(4'b0010);
    step(4'b0010);
    chk("stall_code", 32'(bus.fault_code), 32'd3);

    // 5: async clr mid-track, then restart
    async_clr();
    step(4'b0100); step(4'b1000); step(4'b0001);
    chk("pre_clr_rev", 32'(bus.rev_count), 32'd1);
    async_clr();
    step(4'b0001);
    chk("restart_valid", 32'(bus.phase_valid), 32'd1);
    chk("restart_rev", 32'(bus.rev_count), 32'd0);

    // 6: skip fault, then four clean rotations
    step(4'b0010); step(4'b0100); step(4'b1000); step(4'b0001);
    step(4'b0100);
    chk("rs_skip_code", 32'(bus.fault_code), 32'd2);
    step(4'b1000); step(4'b0001); step(4'b0010); step(4'b0100);
`ifdef RING_MON_RESYNC_EN
    chk("rs_fault", 32'(bus.fault), 32'd0);
    chk("rs_valid", 32'(bus.phase_valid), 32'd1);
    chk("rs_code", 32'(bus.fault_code), 32'd0);
`else
    chk("rs_fault", 32'(bus.fault), 32'd1);
    chk("rs_valid", 32'(bus.phase_valid), 32'd0);
`endif
    chk("rs_rev", 32'(bus.rev_count), 32'd1);

    // Random: mostly clean rotation with occasional corruption and clr pulses
    last_v = 4'b0100;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) rv = 4'($urandom_range(0, 15));
      else if ($countones(last_v) == 1) rv = {last_v[2:0], last_v[3]};
      else rv = 4'b0001;
      step(rv);
      last_v = rv;
      if ($urandom_range(0, 79) == 0) async_clr();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
